piso_shift_ctrl: RTL and testbench
==================================

// Module: piso_shift_ctrl
// PURPOSE
//  Sequences a WIDTH-bit parallel-in/serial-out shift register built from per-bit load/shift cells.
//  Accepts a parallel word on a valid/ready handshake and issues per-cycle load/shift/hold selects.
//  Emits the word one bit per accepted beat on a serial valid/ready stream.
//  Sits between a word-producing datapath and any bit-serial sink (LED/UART-style test outputs).
// PARAMETERS
//  WIDTH      8   bits per word; legal range >= 2
//  MSB_FIRST  1   1: bit WIDTH-1 leaves first; 0: bit 0 leaves first
// PORTS
//  clk        in   1            system clock, rising edge
//  rst        in   1            asynchronous, active-high reset
//  in_data    in   WIDTH        parallel word to serialize
//  in_valid   in   1            in_data valid
//  in_ready   out  1            controller can take a word this cycle
//  ser_out    out  1            current serial bit
//  ser_valid  out  1            ser_out valid
//  ser_ready  in   1            sink accepts ser_out this cycle
//  ser_last   out  1            ser_out is final bit of the word
//  bit_cnt    out  $clog2(WIDTH) index of the bit currently presented (0..WIDTH-1)
// BEHAVIOUR
//  Clock and reset: one clock, clk. rst is asynchronous and active-high.
//  Reset (async, immediate): state=S_IDLE, shift reg=0, bit_cnt=0, ser_valid=0, ser_last=0, ser_out=0.
//    in_ready=1 once reset is released.
//  States:
//    S_IDLE : in_ready=1, ser_valid=0, shift reg holds.
//      On in_valid, load in_data, bit_cnt=0, go to S_SHIFT.
//    S_SHIFT: ser_valid=1. ser_out = sreg[WIDTH-1] if MSB_FIRST, else sreg[0].
//      On ser_ready, shift by one and bit_cnt++.
//      With no ser_ready, hold: ser_out, bit_cnt and sreg stay stable.
//  ser_last=1 iff S_SHIFT and bit_cnt==WIDTH-1.
//  in_ready: 1 in S_IDLE, or in S_SHIFT when ser_ready & ser_last (same-cycle refill). Otherwise 0.
//  End of word, on ser_valid&ser_ready&ser_last:
//    with in_valid: load the new word, bit_cnt=0, stay in S_SHIFT (no bubble).
//    without in_valid: go to S_IDLE.
//  Latency: word accepted at edge N -> first bit valid after edge N (cycle N+1).
//    With ser_ready held high, the word completes WIDTH cycles later.
//  Cell select per cycle: load = word accept; shift = ser_valid&ser_ready&!load; otherwise hold.
//    Load has priority over shift.
//  bit_cnt never exceeds WIDTH-1. It wraps to 0 only via load.
//  Shift fill value is 0.
//  Reset mid-word: the word is discarded and nothing resumes.
//    The first word after reset starts at bit 0.
// STRUCTURE
//  Package sr_ctrl_pkg:
//    typedef enum logic [0:0] {S_IDLE, S_SHIFT} sr_state_t;
//    typedef enum logic [1:0] {SEL_HOLD, SEL_LOAD, SEL_SHIFT} sr_sel_t;
//  Sub-module shift_chain #(WIDTH, MSB_FIRST): WIDTH-bit register with load/shift/hold select.
//    Hold is implemented as load-of-self in each cell.
//    shift_chain exposes sreg. The controller keeps the FSM, bit counter and handshake logic.
// TESTING
//  1. MSB_FIRST=1, in_data=8'hC1, ser_ready=1.
//     -> ser_out 1,1,0,0,0,0,0,1 on 8 consecutive cycles.
//     -> ser_last only on the 8th; in_ready=1 on the 8th.
//  2. MSB_FIRST=0, in_data=8'hC1.
//     -> ser_out 1,0,0,0,0,0,1,1; bit_cnt 0..7.
//  3. 8'hC1 with ser_ready pseudo-random (~50%).
//     -> ser_out/bit_cnt stable while stalled; all 8 bits exact; no drop or duplicate.
//  4. in_valid held, words 8'hC1 then 8'h5A, ser_ready=1.
//     -> 16 contiguous ser_valid cycles, 1100_0001_0101_1010.
//  5. in_valid asserted with 8'hFF mid-word.
//     -> in_ready=0, word not taken until the current word's last beat; no corruption.
//  6. Assert rst after 3 bits of 8'hC1.
//     -> ser_valid=0 and ser_last=0 immediately (before the next edge).
//     -> after release, 8'h81 serializes 1,0,0,0,0,0,0,1 from bit_cnt=0.

Source files
------------

// File: rtl/sr_ctrl_pkg.sv
// Shared types for the PISO shift controller: FSM states and per-cell select codes.
package sr_ctrl_pkg;

    typedef enum logic [0:0] {S_IDLE, S_SHIFT} sr_state_t;

    typedef enum logic [1:0] {SEL_HOLD, SEL_LOAD, SEL_SHIFT} sr_sel_t;

endpackage

// File: rtl/shift_chain.sv
// WIDTH-bit load/shift/hold register; every cell always loads, hold just reloads its own bit.
module shift_chain
    import sr_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  sr_sel_t          sel,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] sreg
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] cell_d;

    // The outgoing bit sits at the top (MSB first) or bottom (LSB first); vacated end fills with 0.
    always_comb begin
        if (MSB_FIRST) begin
            shifted = {sreg[WIDTH-2:0], 1'b0};
        end else begin
            shifted = {1'b0, sreg[WIDTH-1:1]};
        end
    end

    always_comb begin
        cell_d = sreg;
        for (int i = 0; i < WIDTH; i++) begin
            case (sel)
                SEL_LOAD:  cell_d[i] = load_data[i];
                SEL_SHIFT: cell_d[i] = shifted[i];
                default:   cell_d[i] = sreg[i];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
        end else begin
            sreg <= cell_d;
        end
    end

endmodule

// File: rtl/piso_shift_ctrl.sv
// Parallel-in/serial-out controller: word handshake in, one bit per accepted beat out.
//   state   | meaning
//   S_IDLE  | no word held, ready for a new parallel word
//   S_SHIFT | presenting sreg output bit bit_cnt on the serial stream
module piso_shift_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     ser_out,
    output logic                     ser_valid,
    input  logic                     ser_ready,
    output logic                     ser_last,
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    sr_state_t        state, state_nxt;
    logic [CW-1:0]    cnt_nxt;
    sr_sel_t          sel;
    logic             accept;
    logic             fire;
    logic [WIDTH-1:0] sreg;

    shift_chain #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_chain (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .load_data (in_data),
        .sreg      (sreg)
    );

    assign ser_out = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

    always_comb begin
        ser_valid = (state == S_SHIFT);
        ser_last  = ser_valid && (bit_cnt == LAST_IDX);
        fire      = ser_valid && ser_ready;
        // Refill on the final beat keeps the serial stream free of bubbles.
        in_ready  = !rst && ((state == S_IDLE) || (ser_ready && ser_last));
        accept    = in_valid && in_ready;
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        sel       = SEL_HOLD;

        if (accept) begin
            sel = SEL_LOAD;
        end else if (fire) begin
            sel = SEL_SHIFT;
        end

        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_SHIFT;
                    cnt_nxt   = '0;
                end
            end
            S_SHIFT: begin
                if (accept) begin
                    cnt_nxt = '0;
                end else if (fire) begin
                    if (ser_last) begin
                        state_nxt = S_IDLE;
                    end else begin
                        cnt_nxt = bit_cnt + CW'(1);
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_piso_shift_ctrl.sv
// Bench for piso_shift_ctrl: MSB-first and LSB-first instances share stimulus, checked against a word/index model.
module tb_piso_shift_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       ser_ready = 1'b0;

    logic       in_ready_m, ser_out_m, ser_valid_m, ser_last_m;
    logic       in_ready_l, ser_out_l, ser_valid_l, ser_last_l;
    logic [2:0] bit_cnt_m, bit_cnt_l;

    int checks = 0;
    int failures = 0;

    // reference model: busy flag, the word being sent and how many bits have left
    bit         m_busy = 1'b0;
    logic [7:0] m_word = 8'h00;
    int         m_k = 0;
    int         acc_cnt = 0;
    logic       m_erdy = 1'b0;
    logic       sb_m[$];
    logic       sb_l[$];
    logic       got_m[$];
    logic       got_l[$];

    always #5 clk = ~clk;

    piso_shift_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_m),
        .ser_out(ser_out_m), .ser_valid(ser_valid_m), .ser_ready(ser_ready),
        .ser_last(ser_last_m), .bit_cnt(bit_cnt_m)
    );

    piso_shift_ctrl #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_l),
        .ser_out(ser_out_l), .ser_valid(ser_valid_l), .ser_ready(ser_ready),
        .ser_last(ser_last_l), .bit_cnt(bit_cnt_l)
    );

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       sr;
        logic       ev;
        logic       eom;
        logic       eol;
        logic       elast;
        logic       erdy;
        logic [2:0] ecnt;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_k = 0;
        sb_m.delete();
        sb_l.delete();
        got_m.delete();
        got_l.delete();
    endtask

    task automatic model_check();
        logic e_last;
        e_last = m_busy && (m_k == 7);
        m_erdy = !m_busy || (ser_ready && e_last);
        chk("valid_m", ser_valid_m, m_busy);
        chk("valid_l", ser_valid_l, m_busy);
        chk("last_m", ser_last_m, e_last);
        chk("last_l", ser_last_l, e_last);
        chk("in_ready_m", in_ready_m, m_erdy);
        chk("in_ready_l", in_ready_l, m_erdy);
        if (m_busy) begin
            chk("out_m", ser_out_m, m_word[7-m_k]);
            chk("out_l", ser_out_l, m_word[m_k]);
            chk("cnt_m", bit_cnt_m, m_k);
            chk("cnt_l", bit_cnt_l, m_k);
        end
        if (ser_valid_m && ser_ready) begin
            got_m.push_back(ser_out_m);
            got_l.push_back(ser_out_l);
            if (sb_m.size() > 0) begin
                chk("stream_m", ser_out_m, sb_m.pop_front());
                chk("stream_l", ser_out_l, sb_l.pop_front());
            end else begin
                chk("stream_extra_beat", sb_m.size(), 1);
            end
        end
    endtask

    task automatic model_step();
        if (in_valid && m_erdy) begin
            m_busy = 1'b1;
            m_word = in_data;
            m_k = 0;
            acc_cnt++;
            for (int j = 7; j >= 0; j--) sb_m.push_back(in_data[j]);
            for (int j = 0; j < 8; j++) sb_l.push_back(in_data[j]);
        end else if (m_busy && ser_ready) begin
            if (m_k == 7) m_busy = 1'b0;
            else m_k++;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        ser_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {ser_valid_m, ser_valid_l}, 2'b00);
        chk("rst_last", {ser_last_m, ser_last_l}, 2'b00);
        chk("rst_out", {ser_out_m, ser_out_l}, 2'b00);
        chk("rst_cnt", {bit_cnt_m, bit_cnt_l}, 6'd0);
        chk("rst_in_ready", {in_ready_m, in_ready_l}, 2'b00);
        rst = 1'b0;
        model_reset();
    endtask

    // Sends n_words (1 or 2) words; the second is offered gap+1 cycles after the first is taken.
    task automatic run_words(input logic [7:0] w0, input logic [7:0] w1, input int n_words,
                             input int gap, input bit rnd_ready, output int span);
        int start;
        int acc_c0;
        bit done;
        start = acc_cnt;
        acc_c0 = -1;
        done = 1'b0;
        span = 0;
        got_m.delete();
        got_l.delete();
        for (int c = 0; c < 400 && !done; c++) begin
            if (acc_cnt - start == 1 && acc_c0 < 0) acc_c0 = c - 1;
            if (acc_cnt - start == 0) begin
                in_valid = 1'b1;
                in_data = w0;
            end else if (acc_cnt - start < n_words) begin
                in_valid = (c - acc_c0) > gap;
                in_data = w1;
            end else begin
                in_valid = 1'b0;
                in_data = 8'h00;
            end
            ser_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle();
            span = c + 1;
            done = (acc_cnt - start == n_words) && !m_busy;
        end
        in_valid = 1'b0;
        chk("run_done", done, 1'b1);
        chk("run_beats", got_m.size(), 8 * n_words);
        if (got_m.size() == 8 * n_words) begin
            for (int j = 0; j < 8 * n_words; j++) begin
                logic [7:0] w;
                w = (j < 8) ? w0 : w1;
                chk("run_bit_m", got_m[j], w[7-(j%8)]);
                chk("run_bit_l", got_l[j], w[j%8]);
            end
        end
    endtask

    initial begin
        logic [7:0] seq_m;
        logic [7:0] seq_l;
        logic [7:0] seq_81;
        int span;

        seq_m = 8'b1100_0001;
        seq_l = 8'b1000_0011;
        seq_81 = 8'b1000_0001;

        tbl[0] = '{iv: 1'b1, d: 8'hC1, sr: 1'b1, ev: 1'b0, eom: 1'b0, eol: 1'b0,
                   elast: 1'b0, erdy: 1'b1, ecnt: 3'd0};
        for (int i = 1; i <= 8; i++) begin
            tbl[i] = '{iv: 1'b0, d: 8'h00, sr: 1'b1, ev: 1'b1, eom: seq_m[8-i], eol: seq_l[8-i],
                       elast: (i == 8), erdy: (i == 8), ecnt: 3'(i - 1)};
        end
        tbl[9] = '{iv: 1'b0, d: 8'h00, sr: 1'b1, ev: 1'b0, eom: 1'b0, eol: 1'b0,
                   elast: 1'b0, erdy: 1'b1, ecnt: 3'd0};

        do_reset();

        // fixed-vector table: 8'hC1 with ser_ready held high, both bit orders
        for (int i = 0; i < 10; i++) begin
            in_valid = tbl[i].iv;
            in_data = tbl[i].d;
            ser_ready = tbl[i].sr;
            @(negedge clk);
            model_check();
            chk("tbl_valid", {ser_valid_m, ser_valid_l}, {2{tbl[i].ev}});
            chk("tbl_last", {ser_last_m, ser_last_l}, {2{tbl[i].elast}});
            chk("tbl_in_ready", {in_ready_m, in_ready_l}, {2{tbl[i].erdy}});
            if (tbl[i].ev) begin
                chk("tbl_out_m", ser_out_m, tbl[i].eom);
                chk("tbl_out_l", ser_out_l, tbl[i].eol);
                chk("tbl_cnt", {bit_cnt_m, bit_cnt_l}, {2{tbl[i].ecnt}});
            end
            @(posedge clk);
            model_step();
            #1;
        end

        // stalled sink, random ready
        run_words(8'hC1, 8'h00, 1, 0, 1'b1, span);

        // back-to-back words with in_valid held: no bubble between them
        run_words(8'hC1, 8'h5A, 2, 0, 1'b0, span);
        chk("b2b_span", span, 17);

        // new word offered mid-word: held off until the last beat, then taken without a gap
        run_words(8'hC1, 8'hFF, 2, 3, 1'b0, span);
        chk("midword_span", span, 17);

        // reset after three bits: outputs drop before the next edge, next word starts fresh
        in_valid = 1'b1;
        in_data = 8'hC1;
        ser_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        repeat (3) cycle();
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", {ser_valid_m, ser_valid_l}, 2'b00);
        chk("async_last", {ser_last_m, ser_last_l}, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        run_words(8'h81, 8'h00, 1, 0, 1'b0, span);
        if (got_m.size() == 8) begin
            for (int j = 0; j < 8; j++) chk("post_rst_bit", got_m[j], seq_81[7-j]);
        end

        // randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            in_valid = ($urandom_range(0, 2) == 0);
            in_data = 8'($urandom);
            ser_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        in_valid = 1'b0;
        ser_ready = 1'b1;
        for (int c = 0; c < 20; c++) cycle();
        chk("drain_empty", sb_m.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
